// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter
//   Round-robin arbiter for N requesters. A winner keeps its grant across a
//   multi-cycle transfer until it signals last, drops its request, or reaches
//   the MAX_HOLD cycle limit. Priority then rotates past the released owner,
//   and a new winner, if any, is granted on the next edge with no idle bubble.
//
// Parameters
//   N         number of requesters (2..32)
//   MAX_HOLD  maximum consecutive grant cycles per winner, 0 = unlimited
//
// Ports
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   req        in   N    per-requester request level, held for the transfer
//   last       in   N    per-requester end-of-transfer flag
//   gnt        out  N    registered one-hot grant, zero when idle
//   gnt_valid  out  1    registered, OR of gnt
//   gnt_id     out  IDW  registered index of the owner, zero when idle
//   timeout    out  1    registered pulse after a hold-limit release
module rr_hold_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   last,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           timeout
);

  // Hold counter must be able to represent MAX_HOLD itself.
  localparam int unsigned CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit HOLD_EN = (MAX_HOLD != 0);
  // Saturation value: the limit when enabled, otherwise the counter ceiling.
  localparam logic [CW-1:0] CNT_SAT = HOLD_EN ? CW'(MAX_HOLD) : {CW{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           timeout_q, timeout_d;

  logic           owner_req;
  logic           owner_last;
  logic           rel_last;
  logic           rel_drop;
  logic           rel_hold;
  logic           release_c;
  logic [IDW-1:0] ptr_after_owner;
  logic [IDW-1:0] arb_ptr;
  logic           win_valid;
  logic [IDW-1:0] win_idx;

  // Release conditions for the current owner; gnt_id_q is the owner index.
  always_comb begin : release_logic
    owner_req  = req[gnt_id_q];
    owner_last = last[gnt_id_q];
    rel_last   = owner_req & owner_last;
    rel_drop   = ~owner_req;
    rel_hold   = HOLD_EN && (cnt_q == CNT_SAT);
    release_c  = (state_q == BUSY) && (rel_last || rel_drop || rel_hold);
  end

  // Pointer value that takes effect on release: one past the owner, wrapping.
  always_comb begin : ptr_rotate
    if (gnt_id_q == IDW'(N - 1)) begin
      ptr_after_owner = '0;
    end else begin
      ptr_after_owner = gnt_id_q + IDW'(1);
    end
  end

  // Arbitration pointer: on a release the rotated pointer is used in the same
  // cycle so the next owner can be registered without a bubble.
  always_comb begin : arb_ptr_sel
    if (state_q == BUSY) begin
      arb_ptr = ptr_after_owner;
    end else begin
      arb_ptr = ptr_q;
    end
  end

  // Scan req from arb_ptr upward, wrapping; the first set bit wins.
  always_comb begin : arbitrate
    int unsigned idx;
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(arb_ptr) + i) % N;
      if (!win_valid && req[IDW'(idx)]) begin
        win_valid = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (release_c && !win_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin : output_next
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          gnt_valid_d    = 1'b1;
          gnt_id_d       = win_idx;
          cnt_d          = CW'(1);
        end
      end
      BUSY: begin
        if (release_c) begin
          ptr_d     = ptr_after_owner;
          // Timeout is flagged only when the hold limit was the sole cause.
          timeout_d = rel_hold && !rel_last && !rel_drop;
          if (win_valid) begin
            gnt_d          = '0;
            gnt_d[win_idx] = 1'b1;
            gnt_valid_d    = 1'b1;
            gnt_id_d       = win_idx;
            cnt_d          = CW'(1);
          end else begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_id_d    = '0;
            cnt_d       = '0;
          end
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
        cnt_d       = '0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin : data_reg
    if (!rst_n) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Self-checking bench for rr_hold_arbiter with N=4, MAX_HOLD=4. A cycle-level
// behavioural model tracks owner/pointer/hold-count as integers and is compared
// against the DUT on every falling edge; directed steps add literal checks.
module tb_rr_hold_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: owner index (-1 = idle), rotation pointer, cycles held.
  int m_own = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_to  = 1'b0;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // First requester at or after p (wrapping), or -1.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_next(input logic [3:0] r, input logic [3:0] l,
                                     input int own, input int p, input int c,
                                     output int own_n, output int p_n,
                                     output int c_n, output bit to_n);
    bit done, drop, lim;
    int w;
    own_n = own; p_n = p; c_n = c; to_n = 1'b0;
    if (own < 0) begin
      w = pick(r, p);
      if (w >= 0) begin own_n = w; c_n = 1; end
    end else begin
      done = r[own] && l[own];
      drop = !r[own];
      lim  = (MAXH != 0) && (c >= MAXH);
      if (done || drop || lim) begin
        p_n   = (own + 1) % N;
        to_n  = lim && !done && !drop;
        w     = pick(r, p_n);
        own_n = w;
        c_n   = (w >= 0) ? 1 : 0;
      end else begin
        c_n = c + 1;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int o_n, p_n, c_n;
    bit t_n;
    if (!rst_n) begin
      m_own <= -1;
      m_ptr <= 0;
      m_cnt <= 0;
      m_to  <= 1'b0;
    end else begin
      model_next(req, last, m_own, m_ptr, m_cnt, o_n, p_n, c_n, t_n);
      m_own <= o_n;
      m_ptr <= p_n;
      m_cnt <= c_n;
      m_to  <= t_n;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : compare
    logic [3:0] e_gnt;
    e_gnt = (m_own >= 0) ? 4'(1 << m_own) : 4'b0000;
    chk("model_gnt",       32'(gnt),       32'(e_gnt));
    chk("model_gnt_valid", 32'(gnt_valid), 32'(m_own >= 0));
    chk("model_gnt_id",    32'(gnt_id),    32'((m_own >= 0) ? m_own : 0));
    chk("model_timeout",   32'(timeout),   32'(m_to));
  end

  task automatic cyc(input logic [3:0] r, input logic [3:0] l);
    req  = r;
    last = l;
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [3:0] eg, input logic et);
    chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
    chk({nm, "_timeout"}, 32'(timeout), 32'(et));
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 4'b1111;
    last  = 4'b0000;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    // Reset state while all requesting
    chk("rst_gnt",       32'(gnt),       32'(0));
    chk("rst_gnt_valid", 32'(gnt_valid), 32'(0));
    chk("rst_gnt_id",    32'(gnt_id),    32'(0));
    chk("rst_timeout",   32'(timeout),   32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    lit("rst_rel", 4'b0001, 1'b0);
    chk("rst_rel_id", 32'(gnt_id), 32'(0));

    // Round robin with single-cycle transfers
    cyc(4'b1111, 4'b0001); lit("rr1", 4'b0010, 1'b0);
    chk("rr1_id", 32'(gnt_id), 32'(1));
    cyc(4'b1111, 4'b0010); lit("rr2", 4'b0100, 1'b0);
    cyc(4'b1111, 4'b0100); lit("rr3", 4'b1000, 1'b0);
    chk("rr3_id", 32'(gnt_id), 32'(3));
    cyc(4'b1111, 4'b1000); lit("rr4", 4'b0001, 1'b0);
    cyc(4'b0000, 4'b0000); lit("rr_idle", 4'b0000, 1'b0);

    // Hold for 3 cycles, req[0] rising during hold
    cyc(4'b0100, 4'b0000); lit("hold1", 4'b0100, 1'b0);
    cyc(4'b0101, 4'b0000); lit("hold2", 4'b0100, 1'b0);
    cyc(4'b0101, 4'b0000); lit("hold3", 4'b0100, 1'b0);
    cyc(4'b0101, 4'b0100); lit("hold_next", 4'b0001, 1'b0);
    cyc(4'b0000, 4'b0000); lit("hold_idle", 4'b0000, 1'b0);

    // Timeout after 4 cycles
    cyc(4'b1010, 4'b0000); lit("to_c1", 4'b0010, 1'b0);
    repeat (3) begin
      cyc(4'b1010, 4'b0000); lit("to_cn", 4'b0010, 1'b0);
    end
    cyc(4'b1010, 4'b0000); lit("to_fire", 4'b1000, 1'b1);
    // Owner 3 finishes; owner 1 again, last on its 4th cycle
    cyc(4'b1010, 4'b1000); lit("tolast_c1", 4'b0010, 1'b0);
    repeat (3) begin
      cyc(4'b1010, 4'b0000); lit("tolast_cn", 4'b0010, 1'b0);
    end
    cyc(4'b1010, 4'b0010); lit("tolast_hand", 4'b1000, 1'b0);
    cyc(4'b0000, 4'b0000); lit("tolast_idle", 4'b0000, 1'b0);

    // Abandon on 2nd grant cycle
    cyc(4'b1000, 4'b0000); lit("ab_c1", 4'b1000, 1'b0);
    cyc(4'b1000, 4'b0000); lit("ab_c2", 4'b1000, 1'b0);
    cyc(4'b0000, 4'b0000); lit("ab_idle", 4'b0000, 1'b0);
    chk("ab_idle_valid", 32'(gnt_valid), 32'(0));

    // Sole requester re-granted with counter restarted
    cyc(4'b1000, 4'b0000); lit("sole_c1", 4'b1000, 1'b0);
    cyc(4'b1000, 4'b1000); lit("sole_regrant", 4'b1000, 1'b0);
    repeat (3) begin
      cyc(4'b1000, 4'b0000); lit("sole_cn", 4'b1000, 1'b0);
    end
    cyc(4'b1000, 4'b0000); lit("sole_to", 4'b1000, 1'b1);
    cyc(4'b0000, 4'b0000); lit("sole_idle", 4'b0000, 1'b0);

    // Mid-transfer reset with pointer moved to 3 beforehand
    cyc(4'b0100, 4'b0000); lit("mr_c1", 4'b0100, 1'b0);
    cyc(4'b0100, 4'b0100); lit("mr_regrant", 4'b0100, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async_gnt",   32'(gnt),       32'(0));
    chk("mr_async_valid", 32'(gnt_valid), 32'(0));
    @(negedge clk);
    #1;
    req   = 4'b1100;
    last  = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    lit("mr_after", 4'b0100, 1'b0);
    chk("mr_after_id", 32'(gnt_id), 32'(2));
    cyc(4'b0000, 4'b0000); lit("end_idle", 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Parametrised round-robin arbiter for N requesters. Once a requester wins, its grant is held across a multi-cycle transfer until that requester signals `last`, drops its request, or exceeds a hold-time limit. Priority then rotates past the released requester. It sits in front of shared single-port resources (bus, memory port, FIFO write side) where one owner must keep access for a whole burst, replacing single-cycle-grant arbiters in such paths.

## Interface
- `N`, default 8: number of requesters; legal range 2..32.
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per winner; 0 means unlimited, with no timeout.
- Derived width: `IDW = max(1, $clog2(N))`.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic rises on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester request level; held high for the whole transfer.
- `last`  in  N  per-requester end-of-transfer flag; only meaningful for the granted index while its `req` is high.
- `gnt`  out  N  registered one-hot grant; all-zero when idle.
- `gnt_valid`  out  1  registered; equals OR of `gnt`.
- `gnt_id`  out  IDW  registered binary index of the granted requester; 0 when idle.
- `timeout`  out  1  registered one-cycle pulse when a grant was forcibly released by `MAX_HOLD`.

## Operation
- State: `IDLE` (no grant) or `BUSY` (grant held by index `g`). Also holds rotation pointer `ptr` (IDW bits) and hold counter `cnt`, which must be wide enough to reach `MAX_HOLD`.
- Arbitration function: scan `req` from index `ptr` upward, wrapping modulo N. The first set bit wins. `ptr` is the highest-priority index.
- `IDLE`:
  - If `req` is nonzero, the arbitration winner `w` is registered: `gnt` = one-hot(`w`), `gnt_id` = `w`, `cnt` = 1, next state `BUSY`.
  - Otherwise stay `IDLE`.
- `BUSY`, evaluated each cycle. Release occurs if any of these hold:
  - (a) `req[g]` & `last[g]` (normal end);
  - (b) `!req[g]` (abandon);
  - (c) `MAX_HOLD` != 0 and `cnt` == `MAX_HOLD` (timeout).
- Without release: `gnt` unchanged, `cnt` increments, saturating at `MAX_HOLD`.
- On release:
  - `ptr` <= (g+1) mod N.
  - Arbitration is re-run in the same cycle with `ptr` = (g+1) mod N, using the current `req`. Index `g` is therefore lowest priority but may win again if it is the sole requester.
  - If a winner exists, the new grant is registered at the next edge with no idle bubble, and `cnt` = 1.
  - If no winner exists, the next state is `IDLE` and `gnt` = 0.
- `timeout` is asserted for exactly the cycle after a release caused solely by (c). If (a) or (b) holds in the same cycle as (c), `timeout` stays 0.
- `ptr` changes only on release, never while idle.
- Requests arriving or dropping for non-granted indices never affect the current grant.
- Reset, asynchronous and active-low, and valid mid-transfer:
  - `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0, `timeout` = 0, `ptr` = 0, `cnt` = 0, state `IDLE`.
  - After deassertion, arbitration restarts from index 0.

## Timing
- Request-to-grant latency: `req` high at cycle t while `IDLE` gives `gnt` at t+1.
- Release decision is made in a cycle where `gnt[g]` is high. The next owner, or idle, is visible at the following edge.
- A requester asserting `last` on its first grant cycle holds the grant for exactly 1 cycle.
- With `MAX_HOLD` = M, a non-releasing owner holds `gnt` for exactly M cycles.
- `gnt`, `gnt_valid` and `gnt_id` always change together on the same edge. At most one bit of `gnt` is ever set.
- No combinational path from inputs to outputs.

## Test plan
Unless noted, use N=4 and MAX_HOLD=4.
1. Reset state:
   - Hold `rst_n`=0 while `req`=4'b1111 -> all outputs 0.
   - Release reset -> next edge `gnt`=4'b0001, `gnt_id`=0.
2. Round robin:
   - `req`=4'b1111, each owner asserts `last` on its first grant cycle -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, no bubbles.
3. Hold and release:
   - Requester 2 alone, `last` on its 3rd grant cycle, `req[0]` rising during the hold -> `gnt`=0100 for exactly 3 cycles, then 0001 on the next cycle.
4. Timeout:
   - Requester 1 never asserts `last`; `req[3]` is high -> `gnt`=0010 for exactly 4 cycles, then `gnt`=1000 with `timeout`=1 for that one cycle.
   - Repeat with `last[1]` set on the 4th cycle -> same handover, but `timeout`=0.
5. Abandon and sole requester:
   - Requester 3 drops `req` on its 2nd grant cycle, others idle -> `gnt`=0 the next cycle.
   - Requester 3 alone, releasing via `last` while keeping `req` high -> re-granted the next cycle with `cnt` restarted.
6. Mid-transfer reset:
   - Assert `rst_n`=0 asynchronously while `gnt`=0100 -> `gnt`=0 immediately.
   - After release, with `req`=4'b1100 -> `gnt`=0100, since `ptr` was reset to 0.
